// File: rtl/rr_tenure_arbiter_pkg.sv
// rtl/rr_tenure_arbiter_pkg.sv - shared arbitration constants and FSM encoding
package rr_tenure_arbiter_pkg;

  localparam int DEFAULT_N        = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_tenure_arbiter_if.sv
// rtl/rr_tenure_arbiter_if.sv - request/grant bundle between clients and the arbiter
interface rr_tenure_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]         req;
  logic [N-1:0]         ack;
  logic [$clog2(N)-1:0] owner;
  logic                 busy;
  logic [N-1:0]         revoke;

  modport master (output req, input ack, input owner, input busy, input revoke);
  modport slave  (input req, output ack, output owner, output busy, output revoke);
endinterface

// File: rtl/rr_tenure_arbiter_rr_pick.sv
// rtl/rr_tenure_arbiter_rr_pick.sv - combinational round-robin selector starting at ptr
module rr_pick
  import rr_tenure_arbiter_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  localparam logic [PW:0] NVAL = (PW+1)'(N);

  logic [2*N-1:0] w_rot;
  logic [PW-1:0]  w_off;
  logic [PW:0]    w_sum;

  // Rotate so bit 0 is the requester at ptr; lowest set bit is the winner offset.
  always_comb begin
    w_rot = {req, req} >> ptr;
    any   = 1'b0;
    w_off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        any   = 1'b1;
        w_off = PW'(j);
      end
    end
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= NVAL) begin
      w_sum = w_sum - NVAL;
    end
    idx = w_sum[PW-1:0];
  end

endmodule

// File: rtl/rr_tenure_arbiter.sv
// rtl/rr_tenure_arbiter.sv - round-robin arbiter with capped tenure and one-cycle handover gap
module rr_tenure_arbiter
  import rr_tenure_arbiter_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input logic                clk,
  input logic                rst_n,
  rr_tenure_arbiter_if.slave bus
);

  localparam int PW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t    r_state, w_state_nxt;
  logic [N-1:0]  r_ack, w_ack_nxt;
  logic [N-1:0]  r_revoke, w_revoke_nxt;
  logic [PW-1:0] r_owner, w_owner_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic          r_busy, w_busy_nxt;

  logic          w_any;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_owner_inc;

  rr_pick #(.N(N)) u_pick (
    .req (bus.req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  assign w_owner_inc = (r_owner == PW'(N - 1)) ? '0 : r_owner + PW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ack    <= '0;
      r_revoke <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ack    <= w_ack_nxt;
      r_revoke <= w_revoke_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_hold   <= w_hold_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ack_nxt    = r_ack;
    w_revoke_nxt = '0;
    w_owner_nxt  = r_owner;
    w_ptr_nxt    = r_ptr;
    w_hold_nxt   = r_hold;
    w_busy_nxt   = r_busy;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_ack_nxt   = N'(1) << w_idx;
          w_owner_nxt = w_idx;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = HW'(1);
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Voluntary release outranks the tenure cap, so no revoke on a self-release.
        if (!bus.req[r_owner]) begin
          w_ack_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = w_owner_inc;
          w_state_nxt = GAP;
        end else if (r_hold == HW'(MAX_HOLD)) begin
          w_ack_nxt    = '0;
          w_busy_nxt   = 1'b0;
          w_revoke_nxt = r_ack;
          w_ptr_nxt    = w_owner_inc;
          w_state_nxt  = GAP;
        end else begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      GAP: begin
        w_ack_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_ack_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ack    = r_ack;
  assign bus.revoke = r_revoke;
  assign bus.owner  = r_owner;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_rr_tenure_arbiter.sv
// tb/tb_rr_tenure_arbiter.sv - vector table plus scoreboard bench for rr_tenure_arbiter
module tb_rr_tenure_arbiter;

  typedef struct {
    bit         rst_n;
    logic [3:0] req;
    logic [3:0] ack;
    logic [1:0] owner;
    logic [3:0] revoke;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rr_tenure_arbiter_if #(.N(4)) bus ();

  rr_tenure_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input bit r, input logic [3:0] rq, input logic [3:0] a,
                     input logic [1:0] o, input logic [3:0] rv, input int n);
    for (int k = 0; k < n; k++) vecs.push_back('{r, rq, a, o, rv});
  endtask

  task automatic invariants();
    chk("onehot0", 32'($onehot0(bus.ack)), 32'd1);
    chk("busy_eq_ack", 32'(bus.busy), 32'(bus.ack != 4'b0));
    chk("revoke_vs_ack", 32'(bus.ack & bus.revoke), 32'd0);
  endtask

  initial begin
    vec_t e;
    int   lat;
    int   high;
    int   zeros;

    bus.req = 4'b0;

    // reset
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 2);
    // single requester, then ptr=1 proven by 3 beating 0
    add(1, 4'b0001, 4'b0001, 0, 4'b0000, 3);
    add(1, 4'b0000, 4'b0000, 0, 4'b0000, 3);
    add(1, 4'b1001, 4'b1000, 3, 4'b0000, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0000, 2);
    // contention fairness 0,1,2,3,0 with two zero cycles between grants
    add(1, 4'b1111, 4'b0001, 0, 4'b0000, 1);
    add(1, 4'b1110, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b1111, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b1111, 4'b0010, 1, 4'b0000, 1);
    add(1, 4'b1101, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b1111, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b1111, 4'b0100, 2, 4'b0000, 1);
    add(1, 4'b1011, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b1111, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b1111, 4'b1000, 3, 4'b0000, 1);
    add(1, 4'b0111, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b1111, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b1111, 4'b0001, 0, 4'b0000, 1);
    add(1, 4'b1110, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0000, 2);
    // tenure cap on requester 1, then re-grant as sole requester
    add(1, 4'b0010, 4'b0010, 1, 4'b0000, 8);
    add(1, 4'b0010, 4'b0000, 0, 4'b0010, 1);
    add(1, 4'b0010, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b0010, 4'b0010, 1, 4'b0000, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0000, 2);
    // revoke fairness with req=0011
    add(1, 4'b0011, 4'b0001, 0, 4'b0000, 8);
    add(1, 4'b0011, 4'b0000, 0, 4'b0001, 1);
    add(1, 4'b0011, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b0011, 4'b0010, 1, 4'b0000, 8);
    add(1, 4'b0011, 4'b0000, 0, 4'b0010, 1);
    add(1, 4'b0011, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b0011, 4'b0001, 0, 4'b0000, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0000, 2);
    // wrap and skip: move ptr to 3, then 0101 -> 0, then 0100 -> 2
    add(1, 4'b0100, 4'b0100, 2, 4'b0000, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0000, 2);
    add(1, 4'b0101, 4'b0001, 0, 4'b0000, 1);
    add(1, 4'b0100, 4'b0000, 0, 4'b0000, 2);
    add(1, 4'b0100, 4'b0100, 2, 4'b0000, 1);
    // reset mid-grant, then 1111 starts at requester 0
    add(0, 4'b1111, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b1111, 4'b0001, 0, 4'b0000, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0000, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n   = vecs[i].rst_n;
      bus.req = vecs[i].req;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("ack[%0d]", i), 32'(bus.ack), 32'(e.ack));
      chk($sformatf("revoke[%0d]", i), 32'(bus.revoke), 32'(e.revoke));
      if (e.ack != 4'b0) chk($sformatf("owner[%0d]", i), 32'(bus.owner), 32'(e.owner));
      invariants();
    end

    // held request on requester 2: latency, tenure length, revoke, gap length
    @(negedge clk);
    bus.req = 4'b0100;
    lat = 0;
    while (lat < 5) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.ack != 4'b0) break;
    end
    chk("grant_latency", 32'(lat), 32'd1);
    chk("grant_vector", 32'(bus.ack), 32'h4);
    high = 1;
    while (high < 20) begin
      @(posedge clk);
      #1;
      invariants();
      if (bus.ack == 4'b0) break;
      high++;
    end
    chk("tenure_cycles", 32'(high), 32'd8);
    chk("revoke_at_fall", 32'(bus.revoke), 32'h4);
    zeros = 1;
    while (zeros < 10) begin
      @(posedge clk);
      #1;
      if (bus.ack != 4'b0) break;
      chk("revoke_one_cycle", 32'(bus.revoke), 32'd0);
      zeros++;
    end
    chk("gap_zero_cycles", 32'(zeros), 32'd2);
    chk("regrant_vector", 32'(bus.ack), 32'h4);

    @(negedge clk);
    bus.req = 4'b0000;
    @(posedge clk);
    #1;
    chk("final_release", 32'(bus.ack), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
